// File: rtl/seq_player_if.sv
// Control/status bundle for seq_player: sequence editing, playback trigger and lamp outputs.
interface seq_player_if #(
  parameter int DEPTH = 32
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          tick;
  logic          clr;
  logic          append;
  logic [1:0]    append_color;
  logic          play;
  logic [1:0]    out;
  logic          out_ena;
  logic          busy;
  logic          done;
  logic [LW-1:0] len;
  logic          full;

  modport master (
    output tick, clr, append, append_color, play,
    input  out, out_ena, busy, done, len, full
  );

  modport slave (
    input  tick, clr, append, append_color, play,
    output out, out_ena, busy, done, len, full
  );
endinterface

// File: rtl/seq_player.sv
// Colour sequence recorder/player: stores up to DEPTH 2-bit colours and replays them
// as lit/dark lamp phases timed by an external tick strobe.
module seq_player #(
  parameter int DEPTH     = 32,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_player_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]    ON_LAST  = 8'(ON_TICKS - 1);
  localparam logic [7:0]    OFF_LAST = 8'(OFF_TICKS - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [AW-1:0] IDX0     = '0;

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    mem [DEPTH];
  logic [LW-1:0] len, len_nxt;
  logic [AW-1:0] idx, idx_nxt, idx_inc;
  logic [7:0]    cnt, cnt_nxt;
  logic [1:0]    out_q, out_nxt;
  logic          ena_q, ena_nxt;
  logic          busy_q;
  logic          done_q, done_nxt;
  logic          full, app_ok, last;

  assign full    = (len == DEPTH_L);
  assign app_ok  = bus.append && !bus.clr && !full && !busy_q;
  assign idx_inc = idx + AW'(1);
  assign last    = (({1'b0, idx} + LW'(1)) == len);
  assign len_nxt = bus.clr ? '0 : (app_ok ? len + LW'(1) : len);

  // Storage: data only, written at the current tail; no reset needed
  always_ff @(posedge clk) begin
    if (app_ok) mem[len[AW-1:0]] <= bus.append_color;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    ena_nxt   = ena_q;
    done_nxt  = 1'b0;
    if (bus.clr && state != IDLE) begin
      // Abort: silently return to idle, no completion pulse
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      out_nxt   = '0;
      ena_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.play && !bus.clr) begin
            if (len != '0 || app_ok) begin
              // A same-cycle append into an empty store supplies the first colour directly
              state_nxt = ON;
              idx_nxt   = '0;
              cnt_nxt   = '0;
              ena_nxt   = 1'b1;
              out_nxt   = (len == '0) ? bus.append_color : mem[IDX0];
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        ON: begin
          if (bus.tick) begin
            if (cnt == ON_LAST) begin
              state_nxt = GAP;
              cnt_nxt   = '0;
              ena_nxt   = 1'b0;
              out_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 8'd1;
            end
          end
        end
        GAP: begin
          if (bus.tick) begin
            if (cnt != OFF_LAST) begin
              cnt_nxt = cnt + 8'd1;
            end else if (last) begin
              state_nxt = IDLE;
              idx_nxt   = '0;
              cnt_nxt   = '0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ON;
              idx_nxt   = idx_inc;
              cnt_nxt   = '0;
              ena_nxt   = 1'b1;
              out_nxt   = mem[idx_inc];
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          out_nxt   = '0;
          ena_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      len    <= '0;
      idx    <= '0;
      cnt    <= '0;
      out_q  <= '0;
      ena_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      len    <= len_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      out_q  <= out_nxt;
      ena_q  <= ena_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= done_nxt;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_ena = ena_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.len     = len;
  assign bus.full    = full;
endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: expected lamp traces are queued when playback is
// requested and compared edge by edge as the design plays.
module tb_seq_player;
  localparam int DEPTH = 4;
  localparam int ON    = 3;
  localparam int OFF   = 2;
  localparam int L     = ON + OFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_player_if #(.DEPTH(DEPTH)) bus ();

  seq_player #(.DEPTH(DEPTH), .ON_TICKS(ON), .OFF_TICKS(OFF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q [$];   // {busy, out_ena, out[1:0], done}
  logic [1:0] cols  [$];   // colours the bench has stored

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] sample();
    return {bus.busy, bus.out_ena, bus.out, bus.done};
  endfunction

  // Tick n is counted at every edge e>0 with e % period == 0; lamp k is lit for
  // ticks [k*L, k*L+ON) and dark until (k+1)*L; done pulses on the edge of the last tick.
  task automatic push_expected(input int n_lamps, input int period);
    int total;
    total = n_lamps * L * period;
    for (int e = 0; e <= total + 2; e++) begin
      int n;
      logic [4:0] r;
      n = e / period;
      if (n < n_lamps * L) begin
        if ((n % L) < ON) r = {1'b1, 1'b1, cols[n / L], 1'b0};
        else              r = 5'b10000;
      end else if (e == total) begin
        r = 5'b00001;
      end else begin
        r = 5'b00000;
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic play_run(input int n_lamps, input int period, input bit inject);
    int total;
    logic [4:0] expv;
    total = n_lamps * L * period;
    push_expected(n_lamps, period);
    bus.play = 1'b1;
    bus.tick = (period == 1);
    for (int e = 0; e <= total + 2; e++) begin
      edge_step();
      bus.play   = 1'b0;
      bus.append = 1'b0;
      if (exp_q.size() == 0) begin
        check($sformatf("queue_empty_e%0d", e), 32'd1, 32'd0);
      end else begin
        expv = exp_q.pop_front();
        check($sformatf("trace_e%0d", e), 32'(sample()), 32'(expv));
      end
      bus.tick = (((e + 1) % period) == 0);
      if (inject && e == 3) begin
        bus.append       = 1'b1;
        bus.append_color = 2'd1;
        bus.play         = 1'b1;
      end
    end
    bus.tick = 1'b0;
  endtask

  task automatic do_append(input logic [1:0] c);
    bus.append       = 1'b1;
    bus.append_color = c;
    edge_step();
    bus.append = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    edge_step();
    bus.clr = 1'b0;
    cols.delete();
    check("clr_len", 32'(bus.len), 32'd0);
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.clr = 1'b0;
    bus.append = 1'b0;
    bus.append_color = 2'd0;
    bus.play = 1'b0;

    // Reset state
    repeat (2) edge_step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ena",  32'(bus.out_ena), 32'd0);
    check("rst_out",  32'(bus.out), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_len",  32'(bus.len), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty play on the first edge after reset release
    play_run(0, 1, 1'b0);

    // Three colours with append/play injected while busy
    do_append(2'd2); cols.push_back(2'd2); check("len1", 32'(bus.len), 32'd1);
    do_append(2'd1); cols.push_back(2'd1); check("len2", 32'(bus.len), 32'd2);
    do_append(2'd3); cols.push_back(2'd3); check("len3", 32'(bus.len), 32'd3);
    play_run(3, 1, 1'b1);
    check("len_after_busy_append", 32'(bus.len), 32'd3);

    // CLR beats a same-cycle APPEND
    do_clr();
    bus.clr = 1'b1; bus.append = 1'b1; bus.append_color = 2'd3;
    edge_step();
    bus.clr = 1'b0; bus.append = 1'b0;
    check("clr_wins_len", 32'(bus.len), 32'd0);

    // Fill to DEPTH, then one dropped append
    for (int i = 0; i < DEPTH; i++) begin
      logic [1:0] c;
      c = 2'($urandom_range(0, 3));
      do_append(c);
      cols.push_back(c);
      check($sformatf("fill_len%0d", i + 1), 32'(bus.len), 32'(i + 1));
    end
    check("full_set", 32'(bus.full), 32'd1);
    do_append(2'd0);
    check("full_len", 32'(bus.len), 32'(DEPTH));
    check("full_hold", 32'(bus.full), 32'd1);
    play_run(DEPTH, 1, 1'b0);

    // Append accepted in the same cycle as PLAY joins the playback
    do_clr();
    cols.push_back(2'd1);
    bus.append = 1'b1; bus.append_color = 2'd1;
    play_run(1, 1, 1'b0);
    check("same_cycle_len", 32'(bus.len), 32'd1);

    // Slow tick strobe
    do_clr();
    do_append(2'd2); cols.push_back(2'd2);
    play_run(1, 5, 1'b0);

    // CLR in the second ON phase
    do_clr();
    do_append(2'd3); cols.push_back(2'd3);
    do_append(2'd0); cols.push_back(2'd0);
    bus.play = 1'b1; bus.tick = 1'b1;
    edge_step();
    bus.play = 1'b0;
    repeat (6) edge_step();
    check("abort_pre", 32'(sample()), 32'({1'b1, 1'b1, 2'd0, 1'b0}));
    bus.clr = 1'b1;
    edge_step();
    bus.clr = 1'b0;
    check("abort_outs", 32'(sample()), 32'd0);
    check("abort_len",  32'(bus.len), 32'd0);
    edge_step();
    check("abort_nodone", 32'(sample()), 32'd0);
    cols.delete();

    // Asynchronous reset in the middle of a GAP
    do_append(2'd1); cols.push_back(2'd1);
    bus.play = 1'b1;
    edge_step();
    bus.play = 1'b0;
    repeat (3) edge_step();
    check("gap_pre", 32'(sample()), 32'b10000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", 32'(sample()), 32'd0);
    check("arst_len",  32'(bus.len), 32'd0);
    check("arst_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.tick = 1'b0;
    edge_step();
    check("post_rst_idle", 32'(sample()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter DEPTH, default 32: maximum number of stored colour entries; legal values are powers of two from 4 to 64.
REQ-002 Parameter ON_TICKS, default 4: number of TICK strobes a lamp stays lit; legal values are 1 to 255.
REQ-003 Parameter OFF_TICKS, default 2: number of TICK strobes of dark gap after each lamp; legal values are 1 to 255.
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 TICK  in  1  single-cycle timing strobe from the divided time base.
REQ-007 CLR  in  1  empty the stored sequence.
REQ-008 APPEND  in  1  append APPEND_COLOR to the end of the sequence.
REQ-009 APPEND_COLOR  in  2  colour code 0-3.
REQ-010 PLAY  in  1  start playback of the whole stored sequence.
REQ-011 OUT  out  2  colour of the currently lit lamp.
REQ-012 OUT_ENA  out  1  lamp lit.
REQ-013 BUSY  out  1  playback in progress.
REQ-014 DONE  out  1  one-cycle pulse when playback completes.
REQ-015 LEN  out  log2(DEPTH)+1  number of stored entries.
REQ-016 FULL  out  1  LEN equals DEPTH.

Function
REQ-017 Storage SHALL be a DEPTH x 2-bit register array written only by an accepted APPEND at index LEN, after which LEN increments by 1.
REQ-018 APPEND SHALL be ignored when FULL=1 or BUSY=1.
REQ-019 CLR SHALL set LEN to 0 in the next cycle; array contents need not be cleared.
REQ-020 CLR and APPEND asserted in the same cycle: CLR wins, and the append is dropped.
REQ-021 The FSM SHALL have exactly the states IDLE, ON and GAP; BUSY=1 in ON and GAP.
REQ-022 IDLE, PLAY=1, LEN>0:
  - next cycle state=ON, index=0, OUT=mem[0], OUT_ENA=1, tick counter=0.
  - An APPEND accepted in the same cycle is included in the playback.
REQ-023 IDLE, PLAY=1, LEN=0: DONE=1 for exactly the next cycle, state stays IDLE, OUT_ENA stays 0.
REQ-024 PLAY SHALL be ignored when BUSY=1.
REQ-025 ON: each cycle with TICK=1 increments the tick counter; TICK=1 while counter=ON_TICKS-1 moves to GAP next cycle, with OUT_ENA=0, OUT=0, counter=0.
REQ-026 GAP, TICK=1 while counter=OFF_TICKS-1:
  - If index=LEN-1: go to IDLE, DONE=1 for one cycle, BUSY=0.
  - Otherwise: index+1, go to ON, OUT=mem[index+1], OUT_ENA=1, counter=0.
REQ-027 TICK=0 SHALL freeze the counter and state; with TICK tied high, ON lasts exactly ON_TICKS cycles and GAP lasts exactly OFF_TICKS cycles.
REQ-028 CLR during BUSY SHALL abort playback:
  - next cycle state=IDLE, OUT_ENA=0, OUT=0, LEN=0.
  - No DONE pulse.
REQ-029 OUT SHALL be 0 whenever OUT_ENA=0; OUT, OUT_ENA, BUSY and DONE are registered outputs with no combinational path from inputs.
REQ-030 FULL SHALL be derived from LEN in the same cycle.

Reset
REQ-031 RST_N=0 SHALL immediately force state=IDLE, LEN=0, index=0, counter=0, OUT=0, OUT_ENA=0, BUSY=0, DONE=0, FULL=0, including mid-playback.
REQ-032 The first PLAY SHALL be accepted on the first rising edge after RST_N deasserts.

Verification (ON_TICKS=3, OFF_TICKS=2, TICK tied high unless stated)
REQ-033 Append colours 2,1,3 then PLAY -> OUT_ENA waveform high3/low2 repeated three times with OUT=2,1,3; DONE pulses once one cycle after the final gap; BUSY high for exactly 15 cycles.
REQ-034 PLAY with LEN=0 -> DONE=1 for one cycle the next cycle; OUT_ENA and BUSY never assert.
REQ-035 Append DEPTH entries, then one more APPEND -> FULL=1, LEN=DEPTH, the extra entry is dropped; playback shows exactly DEPTH lamps.
REQ-036 TICK strobed once every 5 cycles, single entry -> OUT_ENA high for 3 TICKs, then low for 2 TICKs, then DONE.
REQ-037 CLR in the second ON phase -> next cycle OUT_ENA=0, BUSY=0, LEN=0, no DONE; likewise RST_N pulsed mid-GAP -> all outputs 0 asynchronously.
REQ-038 APPEND during BUSY, and PLAY during BUSY -> both ignored; LEN is unchanged and playback timing is unaffected.
